// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC oversampling sequencer.
//   - sequencer state encoding
//   - default widths for the core result, averaged output and accumulator
//   - AVG_MAX: largest supported log2(sample count)
package adc_seq_pkg;

  localparam int unsigned RES_W_DEF       = 12;
  localparam int unsigned OUT_W_DEF       = 16;
  localparam int unsigned ACC_W_DEF       = 19;
  localparam int unsigned TIMEOUT_CYC_DEF = 1023;

  localparam int unsigned AVG_MAX = 7;
  localparam int unsigned AVG_W   = 3;
  // Sample counter must hold 2^AVG_MAX.
  localparam int unsigned CNT_W   = AVG_MAX + 1;
  localparam int unsigned WD_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/adc_avg_accumulator.sv
// Accumulate-and-shift datapath for the oversampling sequencer.
// Ports:
//   clk, nrst  clock, asynchronous active-low reset
//   clear      zero the accumulator (takes priority over add)
//   add        add the zero-extended sample to the accumulator
//   sample     raw core result
//   shift      log2 of the sample count; average = acc >> shift
//   avg        truncated average, zero-extended/truncated to OUT_W
module adc_avg_accumulator
  import adc_seq_pkg::*;
#(
  parameter int unsigned RES_W = RES_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             add,
  input  logic [RES_W-1:0] sample,
  input  logic [AVG_W-1:0] shift,
  output logic [OUT_W-1:0] avg
);

  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + ACC_W'(sample);
    end
  end

  assign avg = OUT_W'(acc >> shift);

endmodule

// File: rtl/adc_oversample_sequencer.sv
// Oversampling controller for a SAR conversion core. One accepted start
// request launches 2^N back-to-back core conversions, accumulates the
// results and returns the truncated average with a one-cycle finished pulse.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   start_in                  conversion request, honoured only when idle
//   abort_in                  synchronous abort of a running sequence
//   avg_control_in            N (log2 of sample count), captured on start
//   core_start_out            one-cycle start pulse to the SAR core
//   core_done_in              one-cycle done pulse from the SAR core
//   core_result_in            core result, valid with core_done_in
//   result_out                averaged result, held between sequences
//   conversion_finished_out   one-cycle pulse with each result_out update
//   busy_out                  high whenever not idle
//   err_out                   sticky watchdog error
// Optional feature: define ADC_SEQ_WATCHDOG_EN to enable the per-conversion
// watchdog (TIMEOUT_CYC cycles in WAIT); otherwise err_out is tied low.
module adc_oversample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned RES_W       = RES_W_DEF,
  parameter int unsigned OUT_W       = OUT_W_DEF,
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic [AVG_W-1:0] avg_control_in,
  output logic             core_start_out,
  input  logic             core_done_in,
  input  logic [RES_W-1:0] core_result_in,
  output logic [OUT_W-1:0] result_out,
  output logic             conversion_finished_out,
  output logic             busy_out,
  output logic             err_out
);

  seq_state_t       state, state_nxt;
  logic [AVG_W-1:0] n_lat, n_lat_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, cnt_target;
  logic             acc_clear, acc_add, res_load, fin_nxt;
  logic             err_set, err_clr;
  logic [OUT_W-1:0] avg;

  assign cnt_inc    = cnt + 1'b1;
  assign cnt_target = CNT_W'(1) << n_lat;

`ifdef ADC_SEQ_WATCHDOG_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd_cnt <= '0;
    end else if (state == ST_LAUNCH) begin
      wd_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    n_lat_nxt = n_lat;
    cnt_nxt   = cnt;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
    res_load  = 1'b0;
    fin_nxt   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    if (state != ST_IDLE && abort_in) begin
      state_nxt = ST_IDLE;
      acc_clear = 1'b1;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_in) begin
            n_lat_nxt = avg_control_in;
            acc_clear = 1'b1;
            cnt_nxt   = '0;
            err_clr   = 1'b1;
            state_nxt = ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done_in) begin
            acc_add   = 1'b1;
            cnt_nxt   = cnt_inc;
            state_nxt = (cnt_inc == cnt_target) ? ST_DONE : ST_LAUNCH;
          end
`ifdef ADC_SEQ_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            err_set   = 1'b1;
            acc_clear = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end
`endif
        end
        ST_DONE: begin
          res_load  = 1'b1;
          fin_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state                   <= ST_IDLE;
      n_lat                   <= '0;
      cnt                     <= '0;
      result_out              <= '0;
      conversion_finished_out <= 1'b0;
    end else begin
      state                   <= state_nxt;
      n_lat                   <= n_lat_nxt;
      cnt                     <= cnt_nxt;
      conversion_finished_out <= fin_nxt;
      if (res_load) begin
        result_out <= avg;
      end
    end
  end

  // Moore decodes so both drop asynchronously with nrst.
  assign core_start_out = (state == ST_LAUNCH);
  assign busy_out       = (state != ST_IDLE);

  adc_avg_accumulator #(
    .RES_W (RES_W),
    .OUT_W (OUT_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (acc_clear),
    .add    (acc_add),
    .sample (core_result_in),
    .shift  (n_lat),
    .avg    (avg)
  );

endmodule

// File: tb/tb_adc_oversample_sequencer.sv
module tb_adc_oversample_sequencer;

  logic        clk;
  logic        nrst;
  logic        start_in;
  logic        abort_in;
  logic [2:0]  avg_control_in;
  logic        core_start_out;
  logic        core_done_in;
  logic [11:0] core_result_in;
  logic [15:0] result_out;
  logic        conversion_finished_out;
  logic        busy_out;
  logic        err_out;

  adc_oversample_sequencer #(
    .RES_W       (12),
    .OUT_W       (16),
    .ACC_W       (19),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk                     (clk),
    .nrst                    (nrst),
    .start_in                (start_in),
    .abort_in                (abort_in),
    .avg_control_in          (avg_control_in),
    .core_start_out          (core_start_out),
    .core_done_in            (core_done_in),
    .core_result_in          (core_result_in),
    .result_out              (result_out),
    .conversion_finished_out (conversion_finished_out),
    .busy_out                (busy_out),
    .err_out                 (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string nm, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // SAR core stand-in: answers each start pulse after resp_lat cycles with
  // base + idx*step (12-bit). Optionally fires one spurious done in LAUNCH.
  int resp_base = 0, resp_step = 0, resp_lat = 1, resp_idx = 0;
  int starts = 0, last_done_cyc = 0, cd = 0;
  bit resp_on = 1'b1, spur = 1'b0;

  initial begin
    core_done_in   = 1'b0;
    core_result_in = '0;
    forever begin
      @(negedge clk);
      core_done_in = 1'b0;
      if (!resp_on) cd = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_done_in   = 1'b1;
          core_result_in = 12'((resp_base + resp_idx * resp_step) & 'hFFF);
          resp_idx++;
          last_done_cyc  = cyc;
        end
      end
      if (core_start_out) begin
        starts++;
        if (resp_on) begin
          cd = resp_lat;
          if (spur) begin
            core_done_in   = 1'b1;
            core_result_in = 12'hFFF;
            spur           = 1'b0;
          end
        end
      end
    end
  end

  // Reference: the truncated mean of the 2^n values the core returns.
  function automatic int model_avg(input int n, input int base, input int step);
    int sum = 0;
    for (int i = 0; i < (1 << n); i++) sum += (base + i * step) & 'hFFF;
    return sum >> n;
  endfunction

  int hold_res = 0;

  task automatic run_vec(input string nm, input int n, input int base, input int step,
                         input int lat, input int exp_res, input bit scramble);
    bit seen = 1'b0;
    resp_base = base; resp_step = step; resp_lat = lat; resp_idx = 0; starts = 0;
    @(negedge clk);
    start_in = 1'b1;
    avg_control_in = 3'(n);
    @(negedge clk);
    start_in = 1'b0;
    check({nm, " launch"}, core_start_out, 1);
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      if (scramble) avg_control_in = 3'($urandom_range(0, 7));
      if (conversion_finished_out) seen = 1'b1;
    end
    check({nm, " finished"}, seen, 1);
    if (seen) begin
      check({nm, " result"}, result_out, exp_res);
      check({nm, " starts"}, starts, 1 << n);
      check({nm, " latency"}, cyc - last_done_cyc, 2);
      check({nm, " busy"}, busy_out, 0);
      hold_res = exp_res;
      @(negedge clk);
      check({nm, " pulse"}, conversion_finished_out, 0);
    end
  endtask

  typedef struct {
    string nm;
    int    n;
    int    base;
    int    step;
    int    lat;
    int    exp_res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit seen;
    vecs[0] = '{"n0_abc",  0, 'hABC, 0, 1, 'h0ABC};
    vecs[1] = '{"n2_ramp", 2, 100,   1, 2, 101};
    vecs[2] = '{"n7_full", 7, 'hFFF, 0, 1, 'h0FFF};
    vecs[3] = '{"n3_step", 3, 10,    5, 3, 27};
    vecs[4] = '{"n4_ramp", 4, 1000,  3, 4, 1022};
    vecs[5] = '{"n1_flat", 1, 7,     0, 1, 7};

    nrst = 1'b0; start_in = 1'b0; abort_in = 1'b0; avg_control_in = '0;
    repeat (3) @(negedge clk);
    check("rst result", result_out, 0);
    check("rst finished", conversion_finished_out, 0);
    check("rst busy", busy_out, 0);
    check("rst core_start", core_start_out, 0);
    check("rst err", err_out, 0);
    nrst = 1'b1;

    run_vec(vecs[0].nm, vecs[0].n, vecs[0].base, vecs[0].step, vecs[0].lat, vecs[0].exp_res, 1'b0);

    // Abort after three of eight samples.
    resp_base = 50; resp_step = 1; resp_lat = 2; resp_idx = 0;
    @(negedge clk); start_in = 1'b1; avg_control_in = 3'd3;
    @(negedge clk); start_in = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (resp_idx >= 3) seen = 1'b1;
    end
    check("abort reach3", seen, 1);
    check("abort busy_before", busy_out, 1);
    @(negedge clk); abort_in = 1'b1; resp_on = 1'b0;
    @(negedge clk); abort_in = 1'b0;
    check("abort busy", busy_out, 0);
    check("abort core_start", core_start_out, 0);
    check("abort result_hold", result_out, 'h0ABC);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (conversion_finished_out) seen = 1'b1;
    end
    check("abort no_finish", seen, 0);
    resp_on = 1'b1;

    for (int i = 1; i < 6; i++)
      run_vec(vecs[i].nm, vecs[i].n, vecs[i].base, vecs[i].step, vecs[i].lat, vecs[i].exp_res, 1'b0);

    // start_in held through an N=1 sequence, then an immediate restart
    // with a spurious done during LAUNCH.
    resp_base = 200; resp_step = 2; resp_lat = 1; resp_idx = 0; starts = 0;
    @(negedge clk); start_in = 1'b1; avg_control_in = 3'd1;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (conversion_finished_out) seen = 1'b1;
    end
    check("held finished", seen, 1);
    check("held starts", starts, 2);
    check("held result", result_out, 201);
    starts = 0; spur = 1'b1; resp_base = 300; resp_step = 4; resp_idx = 0;
    @(negedge clk);
    check("held restart", core_start_out, 1);
    start_in = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (conversion_finished_out) seen = 1'b1;
    end
    check("spur finished", seen, 1);
    check("spur result", result_out, 302);
    check("spur starts", starts, 2);

    // Asynchronous reset while a second conversion is being launched.
    resp_base = 9; resp_step = 0; resp_lat = 3; resp_idx = 0;
    @(negedge clk); start_in = 1'b1; avg_control_in = 3'd2;
    @(negedge clk); start_in = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (resp_idx >= 1 && core_start_out) seen = 1'b1;
    end
    check("nrst reach", seen, 1);
    resp_on = 1'b0;
    #2 nrst = 1'b0;
    #1;
    check("nrst core_start", core_start_out, 0);
    check("nrst busy", busy_out, 0);
    check("nrst result", result_out, 0);
    check("nrst finished", conversion_finished_out, 0);
    check("nrst err", err_out, 0);
    @(negedge clk); nrst = 1'b1; resp_on = 1'b1;

    for (int i = 0; i < 8; i++) begin
      int n, b, s, l;
      n = int'($urandom_range(0, 5));
      b = int'($urandom_range(0, 4095));
      s = int'($urandom_range(0, 40));
      l = int'($urandom_range(1, 4));
      run_vec($sformatf("rand%0d", i), n, b, s, l, model_avg(n, b, s), 1'b1);
    end

`ifdef ADC_SEQ_WATCHDOG_EN
    resp_on = 1'b0;
    @(negedge clk); start_in = 1'b1; avg_control_in = 3'd0;
    @(negedge clk); start_in = 1'b0;
    check("wd launch", core_start_out, 1);
    repeat (16) @(negedge clk);
    check("wd err_early", err_out, 0);
    check("wd busy_early", busy_out, 1);
    @(negedge clk);
    check("wd err", err_out, 1);
    check("wd busy", busy_out, 0);
    check("wd finished", conversion_finished_out, 0);
    check("wd result_hold", result_out, hold_res);
    @(negedge clk); start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
    check("wd err_clear", err_out, 0);
    abort_in = 1'b1;
    @(negedge clk); abort_in = 1'b0; resp_on = 1'b1;
`else
    check("err tied", err_out, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/adc_oversample_sequencer.md
Name: adc_oversample_sequencer

Overview:
- Digital controller between the user-facing start/config interface and the SAR conversion core.
- On one start request, issues 2^N back-to-back core conversions and accumulates the core results.
- Returns the truncated average on result_out with a single-cycle finished pulse.
- Owns all sequencing of the core's start/done handshake; the core itself is not modified.

Parameters:
- RES_W, 12, width of one raw SAR core result.
- OUT_W, 16, width of result_out; must be >= RES_W.
- ACC_W, 19, accumulator width; must be >= RES_W+7.
- TIMEOUT_CYC, 1023, watchdog limit in clk cycles per core conversion (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nrst  in  1  asynchronous active-low reset.
- start_in  in  1  conversion request; level-sampled, honoured only in IDLE.
- abort_in  in  1  synchronous abort; highest priority after reset.
- avg_control_in  in  3  N = log2(sample count), 0..7 → 1..128 samples; captured on accepted start.
- core_start_out  out  1  one-cycle start pulse to SAR core.
- core_done_in  in  1  one-cycle done pulse from SAR core.
- core_result_in  in  RES_W  core result; valid in the cycle core_done_in=1.
- result_out  out  OUT_W  averaged result, zero-extended; holds between conversions.
- conversion_finished_out  out  1  one-cycle pulse, coincident with result_out update.
- busy_out  out  1  high in every state except IDLE.
- err_out  out  1  sticky watchdog error flag.

Behaviour:
- Reset: state=IDLE; acc, cnt, n_lat=0; all outputs 0.
- States:
  - IDLE: if start_in, latch n_lat=avg_control_in, clear acc and cnt, go to LAUNCH; err_out clears on an accepted start.
  - LAUNCH: core_start_out=1 for exactly this cycle; go to WAIT.
  - WAIT: on core_done_in, acc += zero-extended core_result_in and cnt += 1. If cnt+1 == 1<<n_lat go to DONE, else go to LAUNCH.
  - DONE: register result_out = acc >> n_lat (truncation, no rounding, zero-extended to OUT_W); pulse conversion_finished_out; go to IDLE.
- Timing:
  - Accepted start in cycle t → core_start_out high in t+1.
  - Last core_done_in in cycle k → result_out and conversion_finished_out valid in k+2; busy_out low in k+2.
  - A new start in k+2 is accepted.
- Ignored inputs:
  - start_in while busy_out=1 is ignored; no queueing.
  - core_done_in outside WAIT is ignored, including in the same cycle as core_start_out.
  - avg_control_in changes mid-sequence have no effect.
- abort_in=1 in any non-IDLE state → IDLE next cycle. No finished pulse; result_out holds its previous value; acc and cnt are cleared.
- Arithmetic: ACC_W=19 holds 128×4095 = 524160 without overflow; the accumulator never wraps.
- nrst assertion mid-sequence clears everything immediately; core_start_out drops asynchronously.

Optional Feature:
- Macro: ADC_SEQ_WATCHDOG_EN.
- Defined:
  - A 10-bit cycle counter runs in WAIT and restarts on each LAUNCH.
  - If it reaches TIMEOUT_CYC without core_done_in: set err_out=1, go to IDLE, emit no finished pulse, leave result_out unchanged.
- Undefined:
  - No counter logic; err_out is tied 0.
  - WAIT waits indefinitely for core_done_in.

Decomposition:
- Shared package adc_seq_pkg holds:
  - state encoding (IDLE, LAUNCH, WAIT, DONE)
  - RES_W/OUT_W/ACC_W defaults
  - AVG_MAX=7
- One sub-module, adc_avg_accumulator:
  - clear/add/shift datapath: ACC_W accumulator plus barrel right-shift by n_lat.
  - The FSM stays in the top block.

Test Plan:
- N=0, core returns 0xABC → one core_start_out pulse; result_out=0x0ABC; finished exactly 2 cycles after done; busy_out low same cycle.
- N=2, core returns 100, 101, 102, 103 → 4 start pulses; result_out=101 (406>>2).
- N=7, core returns 0xFFF ×128 → no overflow; result_out=0x0FFF; exactly 128 start pulses.
- start_in held high through a whole N=1 sequence → no extra starts while busy; new sequence begins the cycle after finished. A spurious core_done_in in LAUNCH is ignored (count unchanged).
- abort_in after 3 of 8 samples → IDLE next cycle; no finished pulse; result_out keeps prior 0x0ABC. nrst mid-WAIT → all outputs 0 immediately.
- With ADC_SEQ_WATCHDOG_EN and TIMEOUT_CYC=16, core never answers → err_out=1 after 16 WAIT cycles; IDLE; no finished pulse. Next start clears err_out.
